// File: rtl/debug_step_ctrl.sv
// Debug register index stepper: conditions the up/down buttons (sync, debounce,
// edge, auto-repeat) and optionally auto-advances the display index.
`timescale 1ns/1ps

module debug_step_btn #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic Rst,
    input  logic btn,
    output logic db,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          db_q;

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
            db_q <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            db_q <= db;
            // Counter only runs while the synced level disagrees with db.
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rise = db & ~db_q;
endmodule

module debug_step_ctrl #(
    parameter int IDX_W        = 5,
    parameter int IDX_MAX      = 31,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_CYC   = 5000000,
    parameter int AUTO_CYC     = 50000000
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             auto_en,
    output logic [IDX_W-1:0] debug_input,
    output logic             step,
    output logic             dir,
    output logic             up_db,
    output logic             dn_db
);
    localparam int NUM_BTN = 2;
    localparam int RMAX    = (REPEAT_DLY > REPEAT_CYC) ? REPEAT_DLY : REPEAT_CYC;
    localparam int RW      = (RMAX > 1) ? $clog2(RMAX + 1) : 1;
    localparam int AW      = (AUTO_CYC > 1) ? $clog2(AUTO_CYC + 1) : 1;

    typedef enum logic [2:0] {IDLE, HOLD_UP, HOLD_DN, RPT_UP, RPT_DN} state_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] db;
    logic [NUM_BTN-1:0] rise;

    assign btn_raw = {btn_dn, btn_up};

    // Lane 0 is the up button, lane 1 the down button.
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debug_step_btn #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
            .clk  (clk),
            .Rst  (Rst),
            .btn  (btn_raw[g]),
            .db   (db[g]),
            .rise (rise[g])
        );
    end

    assign up_db = db[0];
    assign dn_db = db[1];

    state_t         state;
    logic [RW-1:0]  rep_cnt;
    logic [AW-1:0]  auto_cnt;
    logic           req_vld;
    logic           req_up;

    logic           hold_is_up;
    logic           hold_held;
    logic           hold_opp;
    logic [RW-1:0]  rep_term;
    logic           auto_act;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] idx_dec;

    always_comb begin
        hold_is_up = (state == HOLD_UP) || (state == RPT_UP);
        hold_held  = hold_is_up ? db[0] : db[1];
        hold_opp   = hold_is_up ? db[1] : db[0];
        rep_term   = ((state == RPT_UP) || (state == RPT_DN)) ? RW'(REPEAT_CYC - 1)
                                                              : RW'(REPEAT_DLY - 1);
        auto_act   = (state == IDLE) && auto_en && !db[0] && !db[1];
    end

    assign idx_inc = (debug_input == IDX_W'(IDX_MAX)) ? '0 : debug_input + IDX_W'(1);
    assign idx_dec = (debug_input == '0) ? IDX_W'(IDX_MAX) : debug_input - IDX_W'(1);

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state       <= IDLE;
            rep_cnt     <= '0;
            auto_cnt    <= '0;
            req_vld     <= 1'b0;
            req_up      <= 1'b1;
            debug_input <= '0;
            step        <= 1'b0;
            dir         <= 1'b1;
        end else begin
            // Output stage: apply the step decided on the previous edge.
            step <= req_vld;
            if (req_vld) begin
                dir         <= req_up;
                debug_input <= req_up ? idx_inc : idx_dec;
            end

            req_vld <= 1'b0;

            if (auto_act) begin
                if (auto_cnt == AW'(AUTO_CYC - 1)) begin
                    auto_cnt <= '0;
                    req_vld  <= 1'b1;
                    req_up   <= 1'b1;
                end else begin
                    auto_cnt <= auto_cnt + AW'(1);
                end
            end else begin
                auto_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    // Simultaneous rises leave both db high, so neither branch fires.
                    if (rise[0] && !db[1] && !rise[1]) begin
                        req_vld  <= 1'b1;
                        req_up   <= 1'b1;
                        rep_cnt  <= '0;
                        auto_cnt <= '0;
                        state    <= HOLD_UP;
                    end else if (rise[1] && !db[0] && !rise[0]) begin
                        req_vld  <= 1'b1;
                        req_up   <= 1'b0;
                        rep_cnt  <= '0;
                        auto_cnt <= '0;
                        state    <= HOLD_DN;
                    end
                end
                HOLD_UP, HOLD_DN, RPT_UP, RPT_DN: begin
                    if (!hold_held || hold_opp) begin
                        rep_cnt <= '0;
                        state   <= IDLE;
                    end else if (rep_cnt == rep_term) begin
                        req_vld <= 1'b1;
                        req_up  <= hold_is_up;
                        rep_cnt <= '0;
                        state   <= hold_is_up ? RPT_UP : RPT_DN;
                    end else begin
                        rep_cnt <= rep_cnt + RW'(1);
                    end
                end
                default: begin
                    rep_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_debug_step_ctrl.sv
// Bench for debug_step_ctrl: directed scenarios plus random button/auto_en
// traffic, compared each cycle against an event-level reference model.
`timescale 1ns/1ps

module tb_debug_step_ctrl;
    localparam int IDX_W   = 5;
    localparam int IDX_MAX = 31;
    localparam int DEB     = 4;
    localparam int RD      = 10;
    localparam int RC      = 3;
    localparam int AC      = 8;

    logic             clk = 1'b0;
    logic             Rst;
    logic             btn_up, btn_dn, auto_en;
    logic [IDX_W-1:0] debug_input;
    logic             step, dir, up_db, dn_db;

    int checks = 0, failures = 0, nsteps = 0;

    always #5 clk = ~clk;

    debug_step_ctrl #(
        .IDX_W(IDX_W), .IDX_MAX(IDX_MAX), .DEBOUNCE_CYC(DEB),
        .REPEAT_DLY(RD), .REPEAT_CYC(RC), .AUTO_CYC(AC)
    ) dut (
        .clk(clk), .Rst(Rst), .btn_up(btn_up), .btn_dn(btn_dn), .auto_en(auto_en),
        .debug_input(debug_input), .step(step), .dir(dir), .up_db(up_db), .dn_db(dn_db)
    );

    // Reference model: raw -> synced after two edges, db flips after DEB
    // consecutive disagreeing cycles, held-time arithmetic for repeat.
    bit ms1[2], ms2[2], mdb[2], mdbq[2];
    int mrun[2];
    int mmode;      // 0 idle, 1 holding up, 2 holding down
    int mh, ma, midx;
    bit mreq, mreq_up, mstep, mdir;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms1[i] = 0; ms2[i] = 0; mdb[i] = 0; mdbq[i] = 0; mrun[i] = 0;
        end
        mmode = 0; mh = 0; ma = 0; midx = 0;
        mreq = 0; mreq_up = 1; mstep = 0; mdir = 1;
    endtask

    task automatic model_step();
        bit raw[2];
        bit ru, rdn, nreq, nup, act, held, opp;
        raw[0] = btn_up; raw[1] = btn_dn;
        mstep = mreq;
        if (mreq) begin
            mdir = mreq_up;
            if (mreq_up) midx = (midx == IDX_MAX) ? 0 : midx + 1;
            else         midx = (midx == 0) ? IDX_MAX : midx - 1;
        end
        ru   = mdb[0] && !mdbq[0];
        rdn  = mdb[1] && !mdbq[1];
        nreq = 0; nup = mreq_up;
        act  = (mmode == 0) && auto_en && !mdb[0] && !mdb[1];
        if (act) begin
            ma++;
            if (ma % AC == 0) begin nreq = 1; nup = 1; end
        end else begin
            ma = 0;
        end
        if (mmode == 0) begin
            if (ru && !mdb[1] && !rdn) begin nreq = 1; nup = 1; mmode = 1; mh = 0; end
            else if (rdn && !mdb[0] && !ru) begin nreq = 1; nup = 0; mmode = 2; mh = 0; end
        end else begin
            held = mdb[mmode-1];
            opp  = mdb[2-mmode];
            if (!held || opp) begin
                mmode = 0;
            end else begin
                mh++;
                if (mh == RD || (mh > RD && (mh - RD) % RC == 0)) begin
                    nreq = 1; nup = (mmode == 1);
                end
            end
        end
        mreq = nreq;
        if (nreq) mreq_up = nup;
        for (int i = 0; i < 2; i++) begin
            mdbq[i] = mdb[i];
            if (ms2[i] != mdb[i]) begin
                mrun[i]++;
                if (mrun[i] == DEB) begin mdb[i] = !mdb[i]; mrun[i] = 0; end
            end else begin
                mrun[i] = 0;
            end
            ms2[i] = ms1[i];
            ms1[i] = raw[i];
        end
    endtask

    always @(posedge clk or negedge Rst) begin
        if (!Rst) model_reset();
        else      model_step();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("idx",   32'(debug_input), 32'(midx));
        chk("step",  32'(step),  32'(mstep));
        chk("dir",   32'(dir),   32'(mdir));
        chk("up_db", 32'(up_db), 32'(mdb[0]));
        chk("dn_db", 32'(dn_db), 32'(mdb[1]));
        if (step === 1'b1) nsteps++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        Rst = 1'b0; tick(); tick(); Rst = 1'b1; tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int i0;
        int offs[$];
        int exp_off[4] = '{2, 12, 15, 18};

        // Reset held with a pressed button and auto enabled
        Rst = 1'b0; btn_up = 1'b1; btn_dn = 1'b0; auto_en = 1'b1;
        ticks(5);
        chk("rst_idx", 32'(debug_input), 0);
        chk("rst_up_db", 32'(up_db), 0);
        chk("rst_dir", 32'(dir), 1);
        Rst = 1'b1;
        for (k = 1; k <= 40; k++) begin tick(); if (step === 1'b1) break; end
        chk("rst_latency", k, 8);

        // Reset while in repeat, button stays held through release
        ticks(20);
        Rst = 1'b0; tick();
        chk("midrst_idx", 32'(debug_input), 0);
        tick(); Rst = 1'b1;
        for (k = 1; k <= 40; k++) begin tick(); if (step === 1'b1) break; end
        chk("midrst_latency", k, 8);
        btn_up = 1'b0; auto_en = 1'b0;
        ticks(20);

        // Bounce: 2-cycle pulses never debounce
        do_reset();
        nsteps = 0;
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1; ticks(2); btn_up = 1'b0; ticks(2);
        end
        ticks(10);
        chk("bnc_steps", nsteps, 0);
        chk("bnc_idx", 32'(debug_input), 0);

        // Wrap down from 0
        nsteps = 0;
        btn_dn = 1'b1; ticks(6); btn_dn = 1'b0; ticks(14);
        chk("wrapdn_idx", 32'(debug_input), IDX_MAX);
        chk("wrapdn_dir", 32'(dir), 0);
        chk("wrapdn_steps", nsteps, 1);

        // Wrap up from IDX_MAX
        nsteps = 0;
        btn_up = 1'b1; ticks(6); btn_up = 1'b0; ticks(14);
        chk("wrapup_idx", 32'(debug_input), 0);
        chk("wrapup_dir", 32'(dir), 1);
        chk("wrapup_steps", nsteps, 1);

        // Auto-repeat timing relative to the debounced rise
        btn_up = 1'b1;
        for (k = 0; k < 20 && up_db !== 1'b1; k++) tick();
        chk("ar_db_rise", 32'(up_db), 1);
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (step === 1'b1) offs.push_back(j);
        end
        for (int i = 0; i < 4; i++)
            chk("ar_offset", (offs.size() > i) ? offs[i] : -1, exp_off[i]);
        chk("ar_count", offs.size(), 8);
        btn_up = 1'b0;
        ticks(20);

        // Opposite button during repeat, then both held
        btn_up = 1'b1; ticks(26);
        btn_dn = 1'b1;
        for (k = 0; k < 20 && dn_db !== 1'b1; k++) tick();
        chk("both_dn_db", 32'(dn_db), 1);
        tick(); tick();
        nsteps = 0;
        ticks(20);
        chk("both_steps", nsteps, 0);
        btn_up = 1'b0; btn_dn = 1'b0;
        ticks(15);

        // Auto-advance: three steps in 25 cycles
        i0 = midx;
        auto_en = 1'b1; nsteps = 0;
        ticks(25);
        chk("auto_steps", nsteps, 3);
        chk("auto_idx", 32'(debug_input), (i0 + 3) % (IDX_MAX + 1));

        // Abandoned count restarts from zero
        auto_en = 1'b0; ticks(3);
        auto_en = 1'b1; ticks(5);
        auto_en = 1'b0; ticks(3);
        auto_en = 1'b1; nsteps = 0;
        ticks(7);
        chk("auto_abandon", nsteps, 0);
        ticks(3);
        chk("auto_restart", nsteps, 1);
        auto_en = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                Rst = 1'b0; ticks($urandom_range(1, 2)); Rst = 1'b1;
            end
            btn_up  = ($urandom_range(0, 2) == 0);
            btn_dn  = ($urandom_range(0, 3) == 0);
            auto_en = $urandom_range(0, 1);
            ticks($urandom_range(1, 30));
        end
        btn_up = 1'b0; btn_dn = 1'b0; auto_en = 1'b0;
        ticks(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
